latch_exerciser: RTL and testbench

Synthesizable stimulus-and-check engine for a single-bit D latch, either polarity. It drives d_out/en_out with the same square-wave pattern the team uses for latch characterisation and compares the latch's q against an internal transparent-latch model. It reports a mismatch count, the first failing cycle and a pass flag. It sits beside any d_latch_* variant on a board or in an FPGA self-test wrapper.

---
 rtl/latch_test_pkg.sv | 14 +
 rtl/latch_ref_model.sv | 47 ++++
 rtl/latch_exerciser.sv | 143 ++++++++++++++
 tb/tb_latch_exerciser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/latch_test_pkg.sv
// Shared types and constants for the latch stimulus/check engine.
package latch_test_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] NO_ERR  = 16'hFFFF;
  localparam logic [7:0]  ERR_MAX = 8'd255;

  // Toggle counter width for a given period; a period of 1 still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/latch_ref_model.sv
// Transparent-latch reference: tracks the value the latch must hold and whether
// that value is trustworthy (invalidated when enable closes as data moves).
module latch_ref_model
  import latch_test_pkg::*;
#(
  parameter bit ACTIVE_LVL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic step_in,
  input  logic d_in,
  input  logic en_in,
  input  logic d_nxt_in,
  input  logic en_nxt_in,
  output logic exp_c,
  output logic check_c
);

  logic r_q;
  logic r_valid;
  logic w_act;
  logic w_act_nxt;
  logic w_race;

  assign w_act     = (en_in == ACTIVE_LVL);
  assign w_act_nxt = (en_nxt_in == ACTIVE_LVL);
  // Enable closing on the same edge data toggles leaves the held value ambiguous.
  assign w_race    = w_act && !w_act_nxt && (d_nxt_in != d_in);

  assign exp_c   = w_act ? d_in : r_q;
  assign check_c = w_act || r_valid;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_q     <= 1'b0;
      r_valid <= 1'b0;
    end else if (clr_in) begin
      r_q     <= 1'b0;
      r_valid <= 1'b0;
    end else if (step_in && w_act) begin
      r_q     <= d_in;
      r_valid <= !w_race;
    end
  end

endmodule

// File: rtl/latch_exerciser.sv
// Drives square-wave d/en into a latch under test and scores its q against a
// reference model: mismatch count, first failing cycle and a pass flag.
module latch_exerciser
  import latch_test_pkg::*;
#(
  parameter int unsigned D_PERIOD   = 6,
  parameter int unsigned EN_PERIOD  = 10,
  parameter int unsigned RUN_CYCLES = 300,
  parameter bit          ACTIVE_LVL = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        q_in,
  output logic        d_out,
  output logic        en_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        pass_out,
  output logic [7:0]  err_count_out,
  output logic [15:0] first_err_out
);

  localparam int unsigned DW     = cnt_w(D_PERIOD);
  localparam int unsigned EW     = cnt_w(EN_PERIOD);
  localparam logic [15:0] LAST_N = 16'(RUN_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_n;
  logic [DW-1:0]   r_d_cnt;
  logic [EW-1:0]   r_en_cnt;
  logic            r_d;
  logic            r_en;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [7:0]      r_err;
  logic [15:0]     r_first;

  logic            w_start;
  logic            w_run;
  logic            w_last;
  logic            w_d_wrap;
  logic            w_en_wrap;
  logic            w_d_nxt;
  logic            w_en_nxt;
  logic            w_exp;
  logic            w_check;
  logic            w_mis;
  logic [7:0]      w_err_nxt;

  assign w_start   = start_in && (r_state != RUN);
  assign w_run     = (r_state == RUN);
  assign w_last    = w_run && (r_n == LAST_N);
  assign w_d_wrap  = (r_d_cnt == DW'(D_PERIOD - 1));
  assign w_en_wrap = (r_en_cnt == EW'(EN_PERIOD - 1));
  assign w_d_nxt   = r_d ^ w_d_wrap;
  assign w_en_nxt  = r_en ^ w_en_wrap;
  assign w_mis     = w_run && w_check && (q_in != w_exp);
  assign w_err_nxt = (w_mis && (r_err != ERR_MAX)) ? r_err + 8'd1 : r_err;

  latch_ref_model #(
    .ACTIVE_LVL (ACTIVE_LVL)
  ) u_model (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr_in    (w_start),
    .step_in   (w_run),
    .d_in      (r_d),
    .en_in     (r_en),
    .d_nxt_in  (w_d_nxt),
    .en_nxt_in (w_en_nxt),
    .exp_c     (w_exp),
    .check_c   (w_check)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    if (start_in) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stimulus generation, scoring and status flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_n      <= '0;
      r_d_cnt  <= '0;
      r_en_cnt <= '0;
      r_d      <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_first  <= NO_ERR;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      if (w_start) begin
        r_n      <= '0;
        r_d_cnt  <= '0;
        r_en_cnt <= '0;
        r_d      <= 1'b0;
        r_en     <= 1'b0;
        r_done   <= 1'b0;
        r_pass   <= 1'b0;
        r_err    <= '0;
        r_first  <= NO_ERR;
      end else if (w_run) begin
        r_err <= w_err_nxt;
        if (w_mis && (r_first == NO_ERR)) r_first <= r_n;
        if (w_last) begin
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == 8'd0);
        end else begin
          r_n      <= r_n + 16'd1;
          r_d_cnt  <= w_d_wrap ? '0 : r_d_cnt + DW'(1);
          r_en_cnt <= w_en_wrap ? '0 : r_en_cnt + EW'(1);
          r_d      <= w_d_nxt;
          r_en     <= w_en_nxt;
        end
      end
    end
  end

  assign d_out         = r_d;
  assign en_out        = r_en;
  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign pass_out      = r_pass;
  assign err_count_out = r_err;
  assign first_err_out = r_first;

endmodule

// File: tb/tb_latch_exerciser.sv
// Bench for latch_exerciser: behavioural latches on q_in, an arithmetic model of
// the expected score, and a per-cycle stimulus monitor.
module tb_latch_exerciser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic a_q, b_q, c_q;
  logic a_d, a_en, a_busy, a_done, a_pass;
  logic b_d, b_en, b_busy, b_done, b_pass;
  logic c_d, c_en, c_busy, c_done, c_pass;
  logic [7:0]  a_err, b_err, c_err;
  logic [15:0] a_first, b_first, c_first;

  latch_exerciser u_a (
    .clk_in(clk), .rst_in(rst), .start_in(a_start), .q_in(a_q),
    .d_out(a_d), .en_out(a_en), .busy_out(a_busy), .done_out(a_done),
    .pass_out(a_pass), .err_count_out(a_err), .first_err_out(a_first));

  latch_exerciser #(.ACTIVE_LVL(1'b0)) u_b (
    .clk_in(clk), .rst_in(rst), .start_in(b_start), .q_in(b_q),
    .d_out(b_d), .en_out(b_en), .busy_out(b_busy), .done_out(b_done),
    .pass_out(b_pass), .err_count_out(b_err), .first_err_out(b_first));

  latch_exerciser #(.RUN_CYCLES(600)) u_c (
    .clk_in(clk), .rst_in(rst), .start_in(c_start), .q_in(c_q),
    .d_out(c_d), .en_out(c_en), .busy_out(c_busy), .done_out(c_done),
    .pass_out(c_pass), .err_count_out(c_err), .first_err_out(c_first));

  // Behavioural latches under test (q_in sources).
  int   mode_a = 0;
  logic lat_a = 1'b0, lat_b = 1'b0, lat_c = 1'b0;
  always @(a_d or a_en) if (a_en)  lat_a = a_d;
  always @(b_d or b_en) if (!b_en) lat_b = b_d;
  always @(c_d or c_en) if (c_en)  lat_c = c_d;
  always_comb begin
    case (mode_a)
      1:       a_q = 1'b0;
      2:       a_q = 1'b1;
      default: a_q = lat_a;
    endcase
  end
  assign b_q = lat_b;
  assign c_q = ~lat_c;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Scoring model from first principles (d/en periods 6/10).
  // mode: 0 = ideal latch, 1 = q tied 0, 2 = q tied 1, 3 = inverted latch.
  function automatic void ref_run(input bit lvl, input int run, input int mode,
                                  output int errs, output int first);
    bit held = 0, valid = 0, phys = 0;
    errs = 0;
    first = 32'hFFFF;
    for (int n = 0; n < run; n++) begin
      bit d   = 1'((n / 6) % 2);
      bit en  = 1'((n / 10) % 2);
      bit dn  = 1'(((n + 1) / 6) % 2);
      bit enn = 1'(((n + 1) / 10) % 2);
      bit act = (en == lvl);
      bit q, expq;
      if (act) phys = d;
      case (mode)
        1:       q = 0;
        2:       q = 1;
        3:       q = ~phys;
        default: q = phys;
      endcase
      expq = act ? d : held;
      if ((act || valid) && (q != expq)) begin
        if (errs < 255) errs++;
        if (first == 32'hFFFF) first = n;
      end
      if (act) begin
        held  = d;
        valid = !((enn != lvl) && (dn != d));
      end
    end
  endfunction

  // Per-cycle stimulus monitor for instance A.
  bit mon_a = 0;
  int mon_n = 0;
  always @(negedge clk) begin
    if (mon_a) begin
      if (mon_n < 300) begin
        chk($sformatf("stim_n%0d", mon_n), 32'({a_busy, a_d, a_en}),
            32'({1'b1, 1'((mon_n / 6) % 2), 1'((mon_n / 10) % 2)}));
        mon_n++;
      end else begin
        chk("done_state", 32'({a_busy, a_done}), 32'(2'b01));
        mon_a = 0;
      end
    end
  end

  task automatic check_a_reset(input string nm);
    chk({nm, "_stim"}, 32'({a_d, a_en}), 0);
    chk({nm, "_flags"}, 32'({a_busy, a_done, a_pass}), 0);
    chk({nm, "_err"}, 32'(a_err), 0);
    chk({nm, "_first"}, 32'(a_first), 32'hFFFF);
  endtask

  task automatic run_a(input int mode, input bit glitch, output int cyc);
    mode_a = mode;
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); mon_n = 0; mon_a = 1;
    #1 a_start = 1'b0;
    cyc = 0;
    while (!a_done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (glitch && cyc == 100) a_start = 1'b1;
      if (glitch && cyc == 101) a_start = 1'b0;
    end
    chk("a_done_latency", cyc, 300);
  endtask

  task automatic score_a(input string nm, input int mode);
    int e, f;
    ref_run(1'b1, 300, mode, e, f);
    chk({nm, "_err"}, 32'(a_err), e);
    chk({nm, "_first"}, 32'(a_first), f);
    chk({nm, "_pass"}, 32'(a_pass), (e == 0) ? 1 : 0);
  endtask

  initial begin
    int cyc, e, f;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_a_reset("reset");
    rst = 1'b0;

    // Model pins against hand-derived values.
    ref_run(1'b1, 300, 1, e, f);
    chk("model_tied0_first", f, 10);
    ref_run(1'b1, 300, 2, e, f);
    chk("model_tied1_first", f, 12);
    ref_run(1'b1, 600, 3, e, f);
    chk("model_inv_err", e, 255);

    run_a(0, 0, cyc);
    score_a("good", 0);
    chk("good_pass_lit", 32'(a_pass), 1);
    chk("good_first_lit", 32'(a_first), 32'hFFFF);

    run_a(1, 0, cyc);
    score_a("tied0", 1);
    chk("tied0_first_lit", 32'(a_first), 10);
    chk("tied0_pass_lit", 32'(a_pass), 0);

    run_a(2, 0, cyc);
    score_a("tied1", 2);
    chk("tied1_first_lit", 32'(a_first), 12);

    // Reset in the middle of a run.
    mode_a = 0;
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); mon_n = 0; mon_a = 1;
    #1 a_start = 1'b0;
    repeat (149) @(posedge clk);
    #2 mon_a = 0; rst = 1'b1;
    @(negedge clk);
    check_a_reset("midrun_reset");
    rst = 1'b0;

    run_a(0, 1, cyc);
    score_a("restart_glitch", 0);
    chk("restart_pass_lit", 32'(a_pass), 1);

    // Negative latch.
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 700) begin @(posedge clk); #1; cyc++; end
    chk("b_done_latency", cyc, 300);
    ref_run(1'b0, 300, 0, e, f);
    chk("b_err", 32'(b_err), e);
    chk("b_pass_lit", 32'(b_pass), 1);
    chk("b_first_lit", 32'(b_first), 32'hFFFF);

    // Long run against an inverted latch: saturation.
    @(negedge clk); c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    cyc = 0;
    while (!c_done && cyc < 700) begin @(posedge clk); #1; cyc++; end
    chk("c_done_latency", cyc, 600);
    chk("c_err_sat", 32'(c_err), 255);
    chk("c_first", 32'(c_first), 10);
    chk("c_pass", 32'(c_pass), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
